mvm_chain: RTL and testbench

- Generalised successor to the fixed two-MVM pipeline: a chain of STAGES rtl_mvm instances joined by AXI-Stream links.
- Every link (input, between stages, output) passes through a registered 2-entry skid slice.
- Any stage can be bypassed per a runtime mask. Mask changes happen only through a quiesce/drain FSM.
- Packet and stall counters are provided for bring-up.
- Sits between the NoC AXIS adapter and the MLP controller datapath.

---
 rtl/mvm_chain.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_mvm_chain.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_chain.sv
// Chain of STAGES rtl_mvm blocks joined by 2-entry skid slices. Any stage can be bypassed
// at runtime; the bypass mask changes only after the chain has been gated and drained.

// Two-entry registered slice; ready and valid decode the occupancy flop only.
module mvm_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign push_ready = (count != 2'd2);
  assign pop_valid  = (count != 2'd0);
  assign pop_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

// Stand-in MVM: diagonal weight matrix, every 32-bit lane scaled by WEIGHTS_INIT_SEL+2.
module rtl_mvm #(
  parameter int unsigned DATAW            = 512,
  parameter int unsigned IDW              = 32,
  parameter int unsigned USERW            = 32,
  parameter int unsigned DESTW            = 32,
  parameter int unsigned WEIGHTS_INIT_SEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axis_rx_tvalid,
  output logic             axis_rx_tready,
  input  logic [DATAW-1:0] axis_rx_tdata,
  input  logic             axis_rx_tlast,
  input  logic [IDW-1:0]   axis_rx_tid,
  input  logic [USERW-1:0] axis_rx_tuser,
  input  logic [DESTW-1:0] axis_rx_tdest,
  output logic             axis_tx_tvalid,
  input  logic             axis_tx_tready,
  output logic [DATAW-1:0] axis_tx_tdata,
  output logic             axis_tx_tlast,
  output logic [IDW-1:0]   axis_tx_tid,
  output logic [USERW-1:0] axis_tx_tuser,
  output logic [DESTW-1:0] axis_tx_tdest
);
  localparam int unsigned      LANEW  = 32;
  localparam int unsigned      LANES  = DATAW / LANEW;
  localparam logic [LANEW-1:0] WEIGHT = LANEW'(WEIGHTS_INIT_SEL + 2);

  logic [DATAW-1:0] prod;

  always_comb begin
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i*LANEW +: LANEW] = axis_rx_tdata[i*LANEW +: LANEW] * WEIGHT;
    end
  end

  assign axis_rx_tready = !axis_tx_tvalid || axis_tx_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      axis_tx_tvalid <= 1'b0;
    end else if (axis_rx_tready) begin
      axis_tx_tvalid <= axis_rx_tvalid;
    end
  end

  always_ff @(posedge clk) begin
    if (axis_rx_tvalid && axis_rx_tready) begin
      axis_tx_tdata <= prod;
      axis_tx_tlast <= axis_rx_tlast;
      axis_tx_tid   <= axis_rx_tid;
      axis_tx_tuser <= axis_rx_tuser;
      axis_tx_tdest <= axis_rx_tdest;
    end
  end
endmodule

module mvm_chain #(
  parameter int unsigned       DATAW       = 512,
  parameter int unsigned       IDW         = 32,
  parameter int unsigned       USERW       = 32,
  parameter int unsigned       DESTW       = 32,
  parameter int unsigned       STAGES      = 2,
  parameter logic [STAGES-1:0] BYPASS_INIT = '0,
  parameter int unsigned       DRAIN_QUIET = 64,
  parameter int unsigned       CNTW        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axis_rx_tvalid,
  output logic              axis_rx_tready,
  input  logic [DATAW-1:0]  axis_rx_tdata,
  input  logic              axis_rx_tlast,
  input  logic [IDW-1:0]    axis_rx_tid,
  input  logic [USERW-1:0]  axis_rx_tuser,
  input  logic [DESTW-1:0]  axis_rx_tdest,
  output logic              axis_tx_tvalid,
  input  logic              axis_tx_tready,
  output logic [DATAW-1:0]  axis_tx_tdata,
  output logic              axis_tx_tlast,
  output logic [IDW-1:0]    axis_tx_tid,
  output logic [USERW-1:0]  axis_tx_tuser,
  output logic [DESTW-1:0]  axis_tx_tdest,
  input  logic              cfg_req,
  input  logic [STAGES-1:0] cfg_bypass,
  output logic              cfg_ack,
  output logic [STAGES-1:0] active_bypass,
  output logic              chain_busy,
  output logic [CNTW-1:0]   stat_in_pkts,
  output logic [CNTW-1:0]   stat_out_pkts,
  output logic [CNTW-1:0]   stat_stall_cycles
);
  // Link payload layout: {tlast, tid, tuser, tdest, tdata}
  localparam int unsigned     PW   = DATAW + 1 + IDW + USERW + DESTW;
  localparam int unsigned     QW   = 10;
  localparam logic [CNTW-1:0] CMAX = '1;

  typedef enum logic [1:0] {ST_RUN, ST_BLOCK, ST_DRAIN, ST_APPLY} state_t;

  logic [STAGES:0]   sl_in_valid;
  logic [STAGES:0]   sl_in_ready;
  logic [STAGES:0]   sl_out_valid;
  logic [STAGES:0]   sl_out_ready;
  logic [PW-1:0]     sl_in_data  [STAGES+1];
  logic [PW-1:0]     sl_out_data [STAGES+1];
  logic [STAGES-1:0] mvm_rx_valid;
  logic [STAGES-1:0] mvm_rx_ready;
  logic [STAGES-1:0] mvm_tx_valid;
  logic [STAGES-1:0] mvm_tx_ready;
  logic [PW-1:0]     mvm_tx_data [STAGES];

  state_t            state_q, state_d;
  logic              rx_en;
  logic              rx_open_q, rx_open_d;
  logic [QW-1:0]     quiet_q, quiet_d;
  logic [STAGES-1:0] pending_q, pending_d;
  logic              rx_hs, rx_last_hs, tx_last_hs, link_busy;

  assign rx_hs      = axis_rx_tvalid && axis_rx_tready;
  assign rx_last_hs = rx_hs && axis_rx_tlast;
  assign tx_last_hs = axis_tx_tvalid && axis_tx_tready && axis_tx_tlast;
  assign link_busy  = (|sl_out_valid) || (|mvm_tx_valid);

  assign axis_rx_tready = rx_en && sl_in_ready[0];
  assign sl_in_valid[0] = rx_en && axis_rx_tvalid;
  assign sl_in_data[0]  = {axis_rx_tlast, axis_rx_tid, axis_rx_tuser, axis_rx_tdest, axis_rx_tdata};

  assign axis_tx_tvalid       = sl_out_valid[STAGES];
  assign sl_out_ready[STAGES] = axis_tx_tready;
  assign {axis_tx_tlast, axis_tx_tid, axis_tx_tuser, axis_tx_tdest, axis_tx_tdata} = sl_out_data[STAGES];

  for (genvar s = 0; s <= STAGES; s++) begin : g_slice
    mvm_skid #(.W(PW)) u_slice (
      .clk       (clk),
      .rst       (rst),
      .push_valid(sl_in_valid[s]),
      .push_ready(sl_in_ready[s]),
      .push_data (sl_in_data[s]),
      .pop_valid (sl_out_valid[s]),
      .pop_ready (sl_out_ready[s]),
      .pop_data  (sl_out_data[s])
    );
  end

  // A bypassed MVM sees no input and has its output drained and dropped.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [DATAW-1:0] tx_data;
    logic             tx_last;
    logic [IDW-1:0]   tx_id;
    logic [USERW-1:0] tx_user;
    logic [DESTW-1:0] tx_dest;

    rtl_mvm #(
      .DATAW           (DATAW),
      .IDW             (IDW),
      .USERW           (USERW),
      .DESTW           (DESTW),
      .WEIGHTS_INIT_SEL(s)
    ) u_mvm (
      .clk           (clk),
      .rst           (rst),
      .axis_rx_tvalid(mvm_rx_valid[s]),
      .axis_rx_tready(mvm_rx_ready[s]),
      .axis_rx_tdata (sl_out_data[s][DATAW-1:0]),
      .axis_rx_tlast (sl_out_data[s][PW-1]),
      .axis_rx_tid   (sl_out_data[s][PW-2 -: IDW]),
      .axis_rx_tuser (sl_out_data[s][PW-2-IDW -: USERW]),
      .axis_rx_tdest (sl_out_data[s][DATAW +: DESTW]),
      .axis_tx_tvalid(mvm_tx_valid[s]),
      .axis_tx_tready(mvm_tx_ready[s]),
      .axis_tx_tdata (tx_data),
      .axis_tx_tlast (tx_last),
      .axis_tx_tid   (tx_id),
      .axis_tx_tuser (tx_user),
      .axis_tx_tdest (tx_dest)
    );

    assign mvm_tx_data[s]   = {tx_last, tx_id, tx_user, tx_dest, tx_data};
    assign mvm_rx_valid[s]  = !active_bypass[s] && sl_out_valid[s];
    assign mvm_tx_ready[s]  = active_bypass[s] || sl_in_ready[s+1];
    assign sl_out_ready[s]  = active_bypass[s] ? sl_in_ready[s+1] : mvm_rx_ready[s];
    assign sl_in_valid[s+1] = active_bypass[s] ? sl_out_valid[s] : mvm_tx_valid[s];
    assign sl_in_data[s+1]  = active_bypass[s] ? sl_out_data[s]  : mvm_tx_data[s];
  end

  // Reconfiguration: finish any open packet, gate rx, wait for a quiet chain, swap mask.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    quiet_d   = '0;
    rx_open_d = rx_open_q;
    if (rx_hs) rx_open_d = !axis_rx_tlast;
    case (state_q)
      ST_RUN: begin
        if (cfg_req) begin
          pending_d = cfg_bypass;
          state_d   = rx_open_d ? ST_BLOCK : ST_DRAIN;
        end
      end
      ST_BLOCK: begin
        if (rx_last_hs) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!link_busy) begin
          if (quiet_q == QW'(DRAIN_QUIET - 1)) state_d = ST_APPLY;
          else quiet_d = quiet_q + QW'(1);
        end
      end
      ST_APPLY: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      rx_open_q     <= 1'b0;
      quiet_q       <= '0;
      pending_q     <= BYPASS_INIT;
      active_bypass <= BYPASS_INIT;
      rx_en         <= 1'b0;
      cfg_ack       <= 1'b0;
      chain_busy    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_open_q  <= rx_open_d;
      quiet_q    <= quiet_d;
      pending_q  <= pending_d;
      rx_en      <= (state_d == ST_RUN) || (state_d == ST_BLOCK);
      cfg_ack    <= (state_d == ST_APPLY);
      chain_busy <= (state_d != ST_RUN);
      if (state_d == ST_APPLY) active_bypass <= pending_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_in_pkts      <= '0;
      stat_out_pkts     <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (rx_last_hs && stat_in_pkts != CMAX) stat_in_pkts <= stat_in_pkts + CNTW'(1);
      if (tx_last_hs && stat_out_pkts != CMAX) stat_out_pkts <= stat_out_pkts + CNTW'(1);
      if (axis_tx_tvalid && !axis_tx_tready && stat_stall_cycles != CMAX)
        stat_stall_cycles <= stat_stall_cycles + CNTW'(1);
    end
  end
endmodule

// File: tb/tb_mvm_chain.sv
// Directed bench for mvm_chain: pass-through latency, backpressure, reconfiguration drain,
// MVM arithmetic per bypass mask, reset recovery and counter saturation.
module tb_mvm_chain;
  localparam int unsigned DATAW  = 64;
  localparam int unsigned IDW    = 8;
  localparam int unsigned USERW  = 8;
  localparam int unsigned DESTW  = 8;
  localparam int unsigned STAGES = 2;
  localparam int unsigned DQ     = 8;
  localparam int unsigned CNTW   = 8;
  localparam logic [1:0]  BYP0   = 2'b11;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [7:0]  id;
    logic [7:0]  user;
    logic [7:0]  dest;
  } beat_t;

  logic              clk, rst;
  logic              rx_valid, rx_ready, rx_last;
  logic [DATAW-1:0]  rx_data;
  logic [IDW-1:0]    rx_id;
  logic [USERW-1:0]  rx_user;
  logic [DESTW-1:0]  rx_dest;
  logic              tx_valid, tx_ready, tx_last;
  logic [DATAW-1:0]  tx_data;
  logic [IDW-1:0]    tx_id;
  logic [USERW-1:0]  tx_user;
  logic [DESTW-1:0]  tx_dest;
  logic              cfg_req, cfg_ack, chain_busy;
  logic [STAGES-1:0] cfg_bypass, active_bypass;
  logic [CNTW-1:0]   in_pkts, out_pkts, stalls;

  mvm_chain #(
    .DATAW(DATAW), .IDW(IDW), .USERW(USERW), .DESTW(DESTW), .STAGES(STAGES),
    .BYPASS_INIT(BYP0), .DRAIN_QUIET(DQ), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst),
    .axis_rx_tvalid(rx_valid), .axis_rx_tready(rx_ready), .axis_rx_tdata(rx_data),
    .axis_rx_tlast(rx_last), .axis_rx_tid(rx_id), .axis_rx_tuser(rx_user), .axis_rx_tdest(rx_dest),
    .axis_tx_tvalid(tx_valid), .axis_tx_tready(tx_ready), .axis_tx_tdata(tx_data),
    .axis_tx_tlast(tx_last), .axis_tx_tid(tx_id), .axis_tx_tuser(tx_user), .axis_tx_tdest(tx_dest),
    .cfg_req(cfg_req), .cfg_bypass(cfg_bypass), .cfg_ack(cfg_ack),
    .active_bypass(active_bypass), .chain_busy(chain_busy),
    .stat_in_pkts(in_pkts), .stat_out_pkts(out_pkts), .stat_stall_cycles(stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc = 0, last_tx_cyc = 0, ack_cyc = 0, ack_cnt = 0, stall_model = 0;
  bit    toggle = 1'b0;
  beat_t txq[$];
  int    txc[$];
  int    rxc[$];

  // Port monitor: records delivered beats and cycle stamps for later checks.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      stall_model = 0;
    end else begin
      if (tx_valid && tx_ready) begin
        txq.push_back('{tx_data, tx_last, tx_id, tx_user, tx_dest});
        txc.push_back(cyc);
      end
      if (rx_valid && rx_ready) rxc.push_back(cyc);
      if (tx_valid) last_tx_cyc = cyc;
      if (tx_valid && !tx_ready) stall_model = stall_model + 1;
      if (cfg_ack) begin
        ack_cyc = cyc;
        ack_cnt = ack_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle) tx_ready = ~tx_ready;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l, input logic [7:0] id,
                           input logic [7:0] user, input logic [7:0] dest);
    rx_valid = 1'b1; rx_data = d; rx_last = l; rx_id = id; rx_user = user; rx_dest = dest;
    for (int k = 0; k < 50 && !rx_ready; k++) tick();
    check("rx_accept", 64'(rx_ready), 64'(1));
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    for (int k = 0; k < 3000 && txq.size() < n; k++) tick();
    check("tx_count", 64'(txq.size()), 64'(n));
  endtask

  task automatic reconfig(input logic [1:0] mask);
    cfg_req = 1'b1; cfg_bypass = mask;
    tick();
    cfg_req = 1'b0;
    for (int k = 0; k < 500 && !cfg_ack; k++) tick();
    check("reconfig_mask", 64'(active_bypass), 64'(mask));
    tick();
  endtask

  task automatic clear_mon();
    txq.delete(); txc.delete(); rxc.delete();
  endtask

  initial begin
    int bad;
    int ack_before;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_last = 1'b0; rx_id = '0; rx_user = '0;
    rx_dest = '0; tx_ready = 1'b1; cfg_req = 1'b0; cfg_bypass = '0;
    tick(); tick();
    check("rst_tx_valid", 64'(tx_valid), 64'(0));
    check("rst_rx_ready", 64'(rx_ready), 64'(0));
    check("rst_mask", 64'(active_bypass), 64'(BYP0));
    check("rst_busy_ack", 64'({chain_busy, cfg_ack}), 64'(0));
    check("rst_cnts", 64'({in_pkts, out_pkts, stalls}), 64'(0));
    rst = 1'b0;
    tick();
    check("rx_ready_after_rst", 64'(rx_ready), 64'(1));

    // All-bypass pass-through of a 3-beat packet
    clear_mon();
    send_beat(64'h1, 1'b0, 8'h5, 8'h0, 8'h7);
    send_beat(64'h2, 1'b0, 8'h5, 8'h0, 8'h7);
    send_beat(64'h3, 1'b1, 8'h5, 8'h0, 8'h7);
    wait_tx(3);
    check("a_b0", 64'(txq[0]), 64'(beat_t'{64'h1, 1'b0, 8'h5, 8'h0, 8'h7}));
    check("a_b1", 64'(txq[1]), 64'(beat_t'{64'h2, 1'b0, 8'h5, 8'h0, 8'h7}));
    check("a_b2", 64'(txq[2]), 64'(beat_t'{64'h3, 1'b1, 8'h5, 8'h0, 8'h7}));
    check("a_latency", 64'(txc[0] - rxc[0]), 64'(3));
    check("a_in_pkts", 64'(in_pkts), 64'(1));
    check("a_out_pkts", 64'(out_pkts), 64'(1));

    // Toggling backpressure, 100 single-beat packets
    clear_mon();
    toggle = 1'b1;
    for (int i = 0; i < 100; i++) send_beat(64'(100 + i), 1'b1, 8'(i), 8'h0, 8'h1);
    wait_tx(100);
    toggle = 1'b0; tx_ready = 1'b1;
    tick(); tick();
    bad = 0;
    for (int i = 0; i < txq.size(); i++)
      if (txq[i].data !== 64'(100 + i) || txq[i].id !== 8'(i) || txq[i].last !== 1'b1) bad++;
    check("b_order", 64'(bad), 64'(0));
    check("b_extra", 64'(txq.size()), 64'(100));
    check("b_stalls", 64'(stalls), 64'(stall_model));
    check("b_stall_range", 64'(stall_model >= 95 && stall_model <= 105), 64'(1));
    check("b_in_pkts", 64'(in_pkts), 64'(101));
    check("b_out_pkts", 64'(out_pkts), 64'(101));

    // Reconfigure mid-packet: block until TLAST, drain, apply
    clear_mon();
    send_beat(64'h10, 1'b0, 8'h3, 8'h0, 8'h1);
    cfg_req = 1'b1; cfg_bypass = 2'b01;
    tick();
    cfg_req = 1'b0;
    check("c_busy", 64'(chain_busy), 64'(1));
    send_beat(64'h11, 1'b0, 8'h3, 8'h0, 8'h1);
    send_beat(64'h12, 1'b0, 8'h3, 8'h0, 8'h1);
    send_beat(64'h13, 1'b1, 8'h3, 8'h0, 8'h1);
    check("c_rx_gated", 64'(rx_ready), 64'(0));
    for (int k = 0; k < 500 && !cfg_ack; k++) tick();
    check("c_ack", 64'(cfg_ack), 64'(1));
    check("c_mask", 64'(active_bypass), 64'(2'b01));
    tick();
    check("c_quiet_gap", 64'(ack_cyc - last_tx_cyc), 64'(DQ + 1));
    check("c_rx_back", 64'(rx_ready), 64'(1));
    check("c_ack_pulse", 64'({cfg_ack, chain_busy}), 64'(0));
    check("c_beats", 64'(txq.size()), 64'(4));
    check("c_last_beat", 64'(txq[3]), 64'(beat_t'{64'h13, 1'b1, 8'h3, 8'h0, 8'h1}));

    // MVM arithmetic: stage0 scales lanes by 2, stage1 by 3
    clear_mon();
    send_beat({32'd7, 32'hFFFF_FFFF}, 1'b1, 8'h21, 8'h22, 8'h23);
    wait_tx(1);
    check("d_mask01", 64'(txq[0]), 64'(beat_t'{{32'd21, 32'hFFFF_FFFD}, 1'b1, 8'h21, 8'h22, 8'h23}));
    reconfig(2'b00);
    clear_mon();
    send_beat({32'd7, 32'hFFFF_FFFF}, 1'b1, 8'h31, 8'h32, 8'h33);
    wait_tx(1);
    check("d_mask00", 64'(txq[0]), 64'(beat_t'{{32'd42, 32'hFFFF_FFFA}, 1'b1, 8'h31, 8'h32, 8'h33}));
    reconfig(2'b10);
    clear_mon();
    send_beat({32'd7, 32'hFFFF_FFFF}, 1'b1, 8'h41, 8'h42, 8'h43);
    wait_tx(1);
    check("d_mask10", 64'(txq[0]), 64'(beat_t'{{32'd14, 32'hFFFF_FFFE}, 1'b1, 8'h41, 8'h42, 8'h43}));

    // Reset mid-packet
    tx_ready = 1'b0;
    send_beat(64'hA1, 1'b0, 8'h9, 8'h0, 8'h0);
    send_beat(64'hA2, 1'b0, 8'h9, 8'h0, 8'h0);
    rst = 1'b1;
    tick();
    check("e1_tx_valid", 64'(tx_valid), 64'(0));
    check("e1_cnts", 64'({in_pkts, out_pkts, stalls}), 64'(0));
    check("e1_mask", 64'(active_bypass), 64'(BYP0));
    check("e1_busy", 64'(chain_busy), 64'(0));
    rst = 1'b0;
    tick();

    // Drain held by a stuck sink, then reset during DRAIN
    send_beat(64'hB1, 1'b1, 8'h9, 8'h0, 8'h0);
    cfg_req = 1'b1; cfg_bypass = 2'b00;
    tick();
    cfg_req = 1'b0;
    ack_before = ack_cnt;
    for (int k = 0; k < 40; k++) tick();
    check("e2_hold_busy", 64'(chain_busy), 64'(1));
    check("e2_hold_data", 64'({tx_valid, tx_data}), 64'({1'b1, 64'hB1}));
    check("e2_no_ack", 64'(ack_cnt), 64'(ack_before));
    rst = 1'b1;
    tick();
    check("e2_tx_valid", 64'(tx_valid), 64'(0));
    check("e2_busy", 64'(chain_busy), 64'(0));
    check("e2_mask", 64'(active_bypass), 64'(BYP0));
    check("e2_cnts", 64'({in_pkts, out_pkts, stalls}), 64'(0));
    rst = 1'b0;
    tick();
    clear_mon();
    tx_ready = 1'b1;
    send_beat(64'hC0FFEE, 1'b1, 8'h44, 8'h55, 8'h66);
    wait_tx(1);
    for (int k = 0; k < 10; k++) tick();
    check("e_fresh_only", 64'(txq.size()), 64'(1));
    check("e_fresh", 64'(txq[0]), 64'(beat_t'{64'hC0FFEE, 1'b1, 8'h44, 8'h55, 8'h66}));

    // Counter saturation at 2^CNTW-1
    rst = 1'b1; tick(); rst = 1'b0; tick();
    clear_mon();
    for (int i = 0; i < 254; i++) send_beat(64'(i), 1'b1, 8'(i), 8'h0, 8'h0);
    wait_tx(254);
    check("f_in_254", 64'(in_pkts), 64'(254));
    check("f_out_254", 64'(out_pkts), 64'(254));
    for (int i = 0; i < 3; i++) send_beat(64'(i), 1'b1, 8'h0, 8'h0, 8'h0);
    wait_tx(257);
    tick();
    check("f_in_sat", 64'(in_pkts), 64'(255));
    check("f_out_sat", 64'(out_pkts), 64'(255));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
